// File: rtl/rr_multichan_recorder_if.sv
// Grouped handshake and logging bus of rr_multichan_recorder.
// The recorder uses the slave modport; the driving/consuming side uses master.
interface rr_multichan_recorder_if #(
  parameter int NUM_CHANNELS = 5,
  parameter int TOTAL_WIDTH  = 320
);
  logic [NUM_CHANNELS-1:0] in_valid;
  logic [NUM_CHANNELS-1:0] in_ready;
  logic [TOTAL_WIDTH-1:0]  in_data;
  logic [NUM_CHANNELS-1:0] out_valid;
  logic [NUM_CHANNELS-1:0] out_ready;
  logic [TOTAL_WIDTH-1:0]  out_data;
  logic [NUM_CHANNELS-1:0] logb_valid;
  logic [TOTAL_WIDTH-1:0]  logb_data;
  logic [NUM_CHANNELS-1:0] loge_valid;
  logic                    logb_almful;

  modport master (
    output in_valid, in_data, out_ready, logb_almful,
    input  in_ready, out_valid, out_data, logb_valid, logb_data, loge_valid
  );

  modport slave (
    input  in_valid, in_data, out_ready, logb_almful,
    output in_ready, out_valid, out_data, logb_valid, logb_data, loge_valid
  );
endinterface

// File: rtl/rr_multichan_recorder.sv
// N-channel valid/ready recorder: per-channel FIFOs plus a shared logb/loge logging bus.
// Define RR_RECORDER_CNT_EN to build the per-channel txn_cnt counters and the cnt_clr input.
module rr_multichan_recorder #(
`ifdef RR_RECORDER_CNT_EN
  parameter int CNT_WIDTH = 32,
`endif
  parameter int RR_CHANNEL_WIDTH_BITS = 32,
  parameter int NUM_CHANNELS = 5,
  parameter logic [NUM_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {5{32'd64}},
  parameter int BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic record_en,
`ifdef RR_RECORDER_CNT_EN
  input  logic cnt_clr,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] txn_cnt,
`endif
  rr_multichan_recorder_if.slave bus
);

  function automatic int chan_offset(int idx);
    int acc;
    acc = 0;
    for (int k = 0; k < idx; k++) begin
      acc = acc + int'(CHANNEL_WIDTHS[k]);
    end
    return acc;
  endfunction

  localparam int TOTAL_WIDTH = chan_offset(NUM_CHANNELS);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                    gate_s;
  logic [NUM_CHANNELS-1:0] in_ready_s;
  logic [NUM_CHANNELS-1:0] out_valid_s;
  logic [NUM_CHANNELS-1:0] logb_valid_s;
  logic [NUM_CHANNELS-1:0] loge_valid_s;
  logic [TOTAL_WIDTH-1:0]  out_data_s;
  logic [TOTAL_WIDTH-1:0]  logb_data_s;

  // A nearly full sink stalls every channel at once, but only while recording.
  assign gate_s = record_en & bus.logb_almful;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    localparam int W   = int'(CHANNEL_WIDTHS[ch]);
    localparam int OFF = chan_offset(ch);

    logic [W-1:0]     mem_r [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     payload_s;
    logic [W-1:0]     logb_data_r;
    logic             logb_valid_r;
    logic             loge_valid_r;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    assign payload_s         = bus.in_data[OFF +: W];
    assign full_s            = (cnt_r == CNT_W'(BUF_DEPTH));
    assign in_ready_s[ch]    = ~rst & ~full_s & ~gate_s;
    assign out_valid_s[ch]   = (cnt_r != {CNT_W{1'b0}});
    assign push_s            = bus.in_valid[ch] & in_ready_s[ch];
    assign pop_s             = out_valid_s[ch] & bus.out_ready[ch];
    assign out_data_s[OFF +: W]  = mem_r[rd_ptr_r];
    assign logb_data_s[OFF +: W] = logb_data_r;
    assign logb_valid_s[ch]  = logb_valid_r;
    assign loge_valid_s[ch]  = loge_valid_r;

    // FIFO storage, pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < BUF_DEPTH; k++) begin
          mem_r[k] <= {W{1'b0}};
        end
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= payload_s;
          wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        case ({push_s, pop_s})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
      end
    end

    // Log strobes use record_en as seen in the handshake cycle
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        logb_valid_r <= 1'b0;
        loge_valid_r <= 1'b0;
        logb_data_r  <= {W{1'b0}};
      end else begin
        logb_valid_r <= record_en & push_s;
        loge_valid_r <= record_en & pop_s;
        if (record_en && push_s) begin
          logb_data_r <= payload_s;
        end
      end
    end

`ifdef RR_RECORDER_CNT_EN
    logic [CNT_WIDTH-1:0] txn_cnt_r;

    assign txn_cnt[ch*CNT_WIDTH +: CNT_WIDTH] = txn_cnt_r;

    // Saturating logged-beat counter; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        txn_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (cnt_clr) begin
        txn_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (record_en && push_s && (txn_cnt_r != {CNT_WIDTH{1'b1}})) begin
        txn_cnt_r <= txn_cnt_r + CNT_WIDTH'(1);
      end
    end
`endif
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_data   = out_data_s;
  assign bus.logb_valid = logb_valid_s;
  assign bus.logb_data  = logb_data_s;
  assign bus.loge_valid = loge_valid_s;

endmodule

// File: tb/tb_rr_multichan_recorder.sv
// Scoreboard bench for rr_multichan_recorder: directed beats queue their expected
// outputs and log events; a negedge monitor pops and compares them.
module tb_rr_multichan_recorder;
  localparam int NCH = 5;
  localparam int W   = 64;
  localparam int TW  = NCH * W;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic record_en = 1'b1;
`ifdef RR_RECORDER_CNT_EN
  logic              cnt_clr = 1'b0;
  logic [NCH*4-1:0]  txn_cnt;
`endif

  rr_multichan_recorder_if #(.NUM_CHANNELS(NCH), .TOTAL_WIDTH(TW)) bus ();

  rr_multichan_recorder #(
`ifdef RR_RECORDER_CNT_EN
    .CNT_WIDTH(4),
`endif
    .NUM_CHANNELS(NCH),
    .BUF_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .record_en(record_en),
`ifdef RR_RECORDER_CNT_EN
    .cnt_clr(cnt_clr),
    .txn_cnt(txn_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_out  [NCH][$];
  logic [63:0] exp_logb [NCH][$];
  int exp_loge  [NCH];
  int logb_seen [NCH];
  int loge_seen [NCH];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_seen();
    for (int c = 0; c < NCH; c++) begin
      logb_seen[c] = 0;
      loge_seen[c] = 0;
    end
  endtask

  // Offer one beat, wait (bounded) for acceptance, then queue its expectations.
  task automatic send(input int ch, input logic [63:0] data);
    int waited;
    waited = 0;
    bus.in_valid[ch] = 1'b1;
    bus.in_data[ch*W +: W] = data;
    @(negedge clk);
    while (!bus.in_ready[ch] && waited < TMO) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= TMO) begin
      check("send_timeout", 64'(bus.in_ready[ch]), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid[ch] = 1'b0;
    if (waited < TMO) begin
      exp_out[ch].push_back(data);
      if (record_en) begin
        exp_logb[ch].push_back(data);
        exp_loge[ch]++;
      end
    end
  endtask

  // Monitor: compares every pop, logb and loge against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int c = 0; c < NCH; c++) begin
          if (bus.out_valid[c] && bus.out_ready[c]) begin
            if (exp_out[c].size() == 0) check("out_extra", 64'(bus.out_valid[c]), 64'd0);
            else check("out_data", bus.out_data[c*W +: W], exp_out[c].pop_front());
          end
          if (bus.logb_valid[c]) begin
            logb_seen[c]++;
            if (exp_logb[c].size() == 0) check("logb_extra", 64'(bus.logb_valid[c]), 64'd0);
            else check("logb_data", bus.logb_data[c*W +: W], exp_logb[c].pop_front());
          end
          if (bus.loge_valid[c]) begin
            loge_seen[c]++;
            if (exp_loge[c] == 0) check("loge_extra", 64'(bus.loge_valid[c]), 64'd0);
            else exp_loge[c]--;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < NCH; c++) exp_loge[c] = 0;
    clear_seen();
    bus.in_valid    = '0;
    bus.in_data     = '0;
    bus.out_ready   = 5'b11111;
    bus.logb_almful = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready",   64'(bus.in_ready),   64'd0);
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_logb_valid", 64'(bus.logb_valid), 64'd0);
    check("rst_loge_valid", 64'(bus.loge_valid), 64'd0);
    check("rst_out_data_zero",  64'(bus.out_data == '0),  64'd1);
    check("rst_logb_data_zero", 64'(bus.logb_data == '0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'h1F);
    @(posedge clk);
    #1;

    // Single beat on ch0: out and logb in t+1, loge in t+2
    send(0, 64'hDEAD_BEEF_0000_0001);
    check("t1_out_valid",  64'(bus.out_valid),  64'h01);
    check("t1_logb_valid", 64'(bus.logb_valid), 64'h01);
    check("t1_logb_data",  bus.logb_data[63:0], 64'hDEAD_BEEF_0000_0001);
    check("t1_loge_early", 64'(bus.loge_valid), 64'h00);
    @(posedge clk);
    #1;
    check("t1_loge_valid", 64'(bus.loge_valid), 64'h01);
    check("t1_out_drained", 64'(bus.out_valid), 64'h00);
    @(posedge clk);
    #1;
    check("t1_loge_single", 64'(bus.loge_valid), 64'h00);

    // Full FIFO on ch2 holds back the third beat
    clear_seen();
    bus.out_ready[2] = 1'b0;
    send(2, 64'hAAAA_0000_0000_0002);
    send(2, 64'hBBBB_0000_0000_0002);
    bus.in_valid[2] = 1'b1;
    bus.in_data[2*W +: W] = 64'hCCCC_0000_0000_0002;
    repeat (3) begin
      @(negedge clk);
      check("t2_full_in_ready", 64'(bus.in_ready[2]), 64'd0);
    end
    check("t2_head", bus.out_data[2*W +: W], 64'hAAAA_0000_0000_0002);
    @(posedge clk);
    #1;
    bus.out_ready[2] = 1'b1;
    send(2, 64'hCCCC_0000_0000_0002);
    repeat (5) @(posedge clk);
    #1;
    check("t2_logb_count", 64'(logb_seen[2]), 64'd3);
    check("t2_loge_count", 64'(loge_seen[2]), 64'd3);

    // almful gates all channels; ch1 still drains with loge only
    bus.out_ready[1] = 1'b0;
    send(1, 64'h1111_0000_0000_0001);
    send(1, 64'h1111_0000_0000_0002);
    bus.logb_almful = 1'b1;
    @(negedge clk);
    check("t3_all_gated", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    clear_seen();
    bus.in_valid[3] = 1'b1;
    bus.in_data[3*W +: W] = 64'h3333_0000_0000_0003;
    bus.out_ready[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t3_ch3_blocked", 64'(bus.in_ready[3]), 64'd0);
    end
    @(posedge clk);
    #1;
    check("t3_ch1_loge", 64'(loge_seen[1]), 64'd2);
    check("t3_no_logb", 64'(logb_seen[0] + logb_seen[1] + logb_seen[2] + logb_seen[3] + logb_seen[4]), 64'd0);
    bus.logb_almful = 1'b0;
    @(negedge clk);
    check("t3_ch3_ready", 64'(bus.in_ready[3]), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid[3] = 1'b0;
    exp_out[3].push_back(64'h3333_0000_0000_0003);
    exp_logb[3].push_back(64'h3333_0000_0000_0003);
    exp_loge[3]++;
    repeat (3) @(posedge clk);
    #1;

    // Pass-through: no log strobes, almful ignored
    record_en = 1'b0;
    bus.logb_almful = 1'b1;
    clear_seen();
    for (int i = 0; i < 10; i++) begin
      send(4, 64'h4444_0000_0000_0000 + 64'(i));
    end
    repeat (4) @(posedge clk);
    #1;
    check("t4_logb_none", 64'(logb_seen[4]), 64'd0);
    check("t4_loge_none", 64'(loge_seen[4]), 64'd0);
    check("t4_drained", 64'(exp_out[4].size()), 64'd0);
    bus.logb_almful = 1'b0;
    record_en = 1'b1;

    // Asynchronous reset with two beats buffered on ch0
    bus.out_ready[0] = 1'b0;
    send(0, 64'h5555_0000_0000_0001);
    send(0, 64'h5555_0000_0000_0002);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_in_ready",  64'(bus.in_ready),  64'd0);
    check("t5_logb",      64'(bus.logb_valid), 64'd0);
    check("t5_loge",      64'(bus.loge_valid), 64'd0);
    exp_out[0].delete();
    exp_logb[0].delete();
    exp_loge[0] = 0;
    bus.out_ready[0] = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_post_out_valid", 64'(bus.out_valid[0]), 64'd0);
    check("t5_post_in_ready",  64'(bus.in_ready[0]),  64'd1);

`ifdef RR_RECORDER_CNT_EN
    // Saturating counter and clear-over-increment
    for (int i = 0; i < 17; i++) begin
      send(0, 64'h6666_0000_0000_0000 + 64'(i));
      if (i == 13) check("t6_cnt_14", 64'(txn_cnt[3:0]), 64'hE);
    end
    check("t6_cnt_sat", 64'(txn_cnt[3:0]), 64'hF);
    cnt_clr = 1'b1;
    send(0, 64'h6666_0000_0000_00FF);
    cnt_clr = 1'b0;
    check("t6_cnt_clr", 64'(txn_cnt[3:0]), 64'h0);
`endif

    repeat (6) @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      check("end_out_queue",  64'(exp_out[c].size()),  64'd0);
      check("end_logb_queue", 64'(exp_logb[c].size()), 64'd0);
      check("end_loge_queue", 64'(exp_loge[c]),        64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rr_multichan_recorder.md
Name: rr_multichan_recorder

Overview:
Parametrised N-channel valid/ready recorder; the generalised successor of the per-channel AXI-Lite loggers. Each channel passes through its own BUF_DEPTH-entry FIFO. Accepted input beats are emitted on a shared logging bus as logb, and completed output handshakes as loge. A single logb_almful backpressures all channels together, and record_en switches between record and pass-through mode. Sits between shell and CL on any AXI/AXI-Lite interface with up to 8 channels.

Parameters:
NUM_CHANNELS, 5, number of independent valid/ready channels (1..8)
CHANNEL_WIDTHS, {5{32'd64}}, packed [NUM_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] per-channel payload width; channel i occupies bits starting at sum of widths[0..i-1]
TOTAL_WIDTH, sum(CHANNEL_WIDTHS), concatenated payload width (derived, not overridden)
BUF_DEPTH, 2, per-channel FIFO depth; power of two, >=2
CNT_WIDTH, 32, per-channel transaction counter width (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
record_en  in  1  1 = record mode, 0 = pass-through
in_valid  in  NUM_CHANNELS  upstream valid per channel
in_ready  out  NUM_CHANNELS  upstream ready per channel
in_data  in  TOTAL_WIDTH  upstream payloads, packed per CHANNEL_WIDTHS
out_valid  out  NUM_CHANNELS  downstream valid
out_ready  in  NUM_CHANNELS  downstream ready
out_data  out  TOTAL_WIDTH  downstream payloads (FIFO heads)
logb_valid  out  NUM_CHANNELS  beat-logged strobe
logb_data  out  TOTAL_WIDTH  logged payloads
loge_valid  out  NUM_CHANNELS  transaction-end strobe
logb_almful  in  1  logging sink almost full
txn_cnt  out  NUM_CHANNELS*CNT_WIDTH  per-channel logged-beat counters (RR_RECORDER_CNT_EN only)
cnt_clr  in  1  synchronous counter clear (RR_RECORDER_CNT_EN only)

Behaviour:
- Reset (rst=1, asynchronous): every FIFO is emptied and its pointers and counts are cleared. All outputs go to 0: in_ready, out_valid, out_data, logb_valid, logb_data, loge_valid, txn_cnt. A reset mid-transfer drops buffered beats without emitting any log.
- Per-channel FIFO: cnt[i] counts 0..BUF_DEPTH; pointers are log2(BUF_DEPTH) bits and wrap naturally.
- in_ready[i] = (cnt[i] != BUF_DEPTH) && !(record_en && logb_almful). It is combinational from logb_almful and record_en only, with no path from out_ready.
- push[i] = in_valid[i] && in_ready[i].
- pop[i] = out_valid[i] && out_ready[i].
- out_valid[i] = (cnt[i] != 0); out_data slice = head entry.
- In-to-out latency: 1 cycle. There is no bypass, so a beat pushed in cycle t is visible at the output in t+1.
- Simultaneous push and pop: cnt is unchanged and both pointers advance. Full: push is blocked. Empty: pop is impossible.
- Record mode (record_en=1), in the cycle after each event:
  - after push[i]: logb_valid[i]=1 and logb_data slice i = the pushed payload (registered);
  - after pop[i]: loge_valid[i]=1 (registered);
  - logb_data slice i holds its last value when logb_valid[i]=0.
- logb_almful gates all channels at once, so no channel can accept a beat whose logb would overflow the sink. Beats already in the FIFOs keep draining, and their loge pulses are still emitted.
- Pass-through mode (record_en=0): logb_valid=0 and loge_valid=0; logb_almful is ignored; FIFO flow is unchanged.
- record_en is sampled each cycle. Events are logged according to the record_en value in the cycle the handshake occurs, so a toggle mid-burst has no partial effect.
- Channels are fully independent apart from the shared almful gate.

Optional Feature:
RR_RECORDER_CNT_EN
- Defined: txn_cnt[i] increments by 1 on every push[i] while record_en=1, and saturates at all-ones. cnt_clr=1 zeroes all counters next cycle; clear takes priority over a simultaneous increment.
- Undefined: the txn_cnt and cnt_clr ports are omitted and no counter logic is built.

Test Plan:
- NUM_CHANNELS=5, record_en=1. Ch0 in_data=64'hDEAD_BEEF_0000_0001 with out_ready=1 -> out_valid[0] in t+1; logb_valid[0] in t+1 with matching data; loge_valid[0] in t+2. Other channels stay idle.
- BUF_DEPTH=2, out_ready[2]=0, three beats A,B,C offered -> A and B accepted, in_ready[2]=0 with C held. Then out_ready=1 -> outputs A,B,C in order, 3 logb and 3 loge pulses.
- logb_almful=1 while ch1 holds 2 beats and ch3 offers a beat -> all in_ready=0. Ch1 drains with 2 loge pulses and 0 logb pulses. Deassert -> ch3 is accepted next cycle.
- record_en=0, 10 beats on ch4 -> data passes intact, logb_valid=loge_valid=0 throughout, logb_almful=1 has no effect.
- rst asserted asynchronously mid-cycle with 2 beats buffered on ch0 -> out_valid, in_ready and log strobes drop immediately. After release, cnt=0 and in_ready[0]=1 next edge.
- RR_RECORDER_CNT_EN, CNT_WIDTH=4: 17 pushes on ch0 -> txn_cnt[0]=4'hF (saturated). cnt_clr asserted with a simultaneous push -> 0.
